// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding, playfield geometry and BCD helpers
//   state_t     : IDLE=0 READY=1 PLAY=2 DYING=3 OVER=4
//   geometry    : MIN_Y, MAX_Y, BIRD_L, BIRD_START, HEIGHT_BIRD
//   BCD_MAX     : two-digit BCD ceiling for the score
package flappy_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DYING = 3'd3,
      S_OVER  = 3'd4
   } state_t;
   localparam int MIN_Y       = 45;
   localparam int MAX_Y       = 426;
   localparam int BIRD_L      = 70;
   localparam int BIRD_START  = 235;
   localparam int HEIGHT_BIRD = 19;
   localparam logic [7:0] BCD_MAX = 8'h99;
   // Saturating two-digit BCD increment: 09->10, 99 stays 99
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return v == BCD_MAX ? v : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
   endfunction
endpackage

// File: rtl/flappy_game_ctrl_btn_edge.sv
// btn_edge: synchronizes and debounces the raw flap button, pulses on its rising edge
//   system_clk_i : clock
//   rst_i        : asynchronous active-high reset
//   raw_i        : raw asynchronous button level
//   press_o      : one-cycle pulse, 2+DB_CYCLES cycles after a stable rising change
module btn_edge #(
   parameter int DB_CYCLES = 16
) (
   input  logic system_clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic press_o
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   logic sync1_q, sync2_q, db_q, press_q;
   logic [CW-1:0] cnt_q;
   logic differs, settled;
   // the synchronized level must disagree with the debounced one for DB_CYCLES samples in a row
   assign differs = sync2_q != db_q;
   assign settled = differs && cnt_q == CW'(DB_CYCLES - 1);
   always_ff @(posedge system_clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= (differs && !settled) ? cnt_q + 1'b1 : '0;
         db_q    <= settled ? sync2_q : db_q;
         press_q <= settled && sync2_q;
      end
   end
   assign press_o = press_q;
endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: IDLE/READY/PLAY/DYING/OVER game sequencer with BCD score and best score
//   system_clk_i, rst_i : clock, asynchronous active-high reset
//   tick_i              : frame-rate pulse
//   btnup_i             : raw flap button
//   pass_pulse_i        : a pipe was passed
//   hit_pipe_i          : bird overlaps a pipe
//   bird_pic_b_i        : bird bottom row
//   bird_hold_o, bird_run_o, pipe_run_o, pipe_clear_o : datapath controls
//   score_bcd_o, best_bcd_o : current and best score, 2 BCD digits
//   game_over_o, state_o    : status
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int READY_TICKS = 60,
   parameter int DIE_TICKS   = 45,
   parameter int GROUND_Y    = 424,
   parameter int DB_CYCLES   = 16
) (
   input  logic       system_clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic       btnup_i,
   input  logic       pass_pulse_i,
   input  logic       hit_pipe_i,
   input  logic [9:0] bird_pic_b_i,
   output logic       bird_hold_o,
   output logic       bird_run_o,
   output logic       pipe_run_o,
   output logic       pipe_clear_o,
   output logic [7:0] score_bcd_o,
   output logic [7:0] best_bcd_o,
   output logic       game_over_o,
   output logic [2:0] state_o
);
   state_t state_q, state_d;
   logic [6:0] cnt_q, cnt_d;
   logic [7:0] score_q, score_d, best_q, best_d;
   logic clear_d, press, dead, last_ready, last_die;
   logic bird_hold_q, bird_run_q, pipe_run_q, pipe_clear_q, game_over_q;
   btn_edge #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .system_clk_i(system_clk_i),
      .rst_i       (rst_i),
      .raw_i       (btnup_i),
      .press_o     (press)
   );
   assign dead       = hit_pipe_i || bird_pic_b_i >= 10'(GROUND_Y);
   assign last_ready = cnt_q == 7'(READY_TICKS - 1);
   assign last_die   = cnt_q == 7'(DIE_TICKS - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      best_d  = best_q;
      clear_d = 1'b0;
      case (state_q)
         S_IDLE: if (press) begin
            state_d = S_READY;
            clear_d = 1'b1;
            score_d = '0;
            cnt_d   = '0;
         end
         S_READY: if (tick_i) begin
            state_d = last_ready ? S_PLAY : S_READY;
            cnt_d   = last_ready ? '0 : cnt_q + 7'd1;
         end
         // death outranks a coincident pass
         S_PLAY: if (dead) begin
            state_d = S_DYING;
            cnt_d   = '0;
         end else if (pass_pulse_i) score_d = bcd_inc(score_q);
         // BCD digits compare correctly as plain binary
         S_DYING: if (tick_i) begin
            state_d = last_die ? S_OVER : S_DYING;
            cnt_d   = last_die ? '0 : cnt_q + 7'd1;
            best_d  = (last_die && score_q > best_q) ? score_q : best_q;
         end
         S_OVER: if (press) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge system_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         score_q      <= '0;
         best_q       <= '0;
         bird_hold_q  <= 1'b1;
         bird_run_q   <= 1'b0;
         pipe_run_q   <= 1'b0;
         pipe_clear_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         score_q      <= score_d;
         best_q       <= best_d;
         bird_hold_q  <= state_d == S_IDLE || state_d == S_READY;
         bird_run_q   <= state_d == S_PLAY || state_d == S_DYING;
         pipe_run_q   <= state_d == S_PLAY;
         pipe_clear_q <= clear_d;
         game_over_q  <= state_d == S_OVER;
      end
   end
   assign state_o      = state_q;
   assign score_bcd_o  = score_q;
   assign best_bcd_o   = best_q;
   assign bird_hold_o  = bird_hold_q;
   assign bird_run_o   = bird_run_q;
   assign pipe_run_o   = pipe_run_q;
   assign pipe_clear_o = pipe_clear_q;
   assign game_over_o  = game_over_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: randomized scoreboard bench for the game sequencer
module tb_flappy_game_ctrl;
   logic clk = 1'b0, rst = 1'b1, tick = 1'b0, btn = 1'b0, pass = 1'b0, hit = 1'b0;
   logic [9:0] y = '0;
   logic bird_hold_o, bird_run_o, pipe_run_o, pipe_clear_o, game_over_o;
   logic [7:0] score_bcd_o, best_bcd_o;
   logic [2:0] state_o;
   always #5 clk = ~clk;
   flappy_game_ctrl dut (
      .system_clk_i(clk),
      .rst_i       (rst),
      .tick_i      (tick),
      .btnup_i     (btn),
      .pass_pulse_i(pass),
      .hit_pipe_i  (hit),
      .bird_pic_b_i(y),
      .bird_hold_o (bird_hold_o),
      .bird_run_o  (bird_run_o),
      .pipe_run_o  (pipe_run_o),
      .pipe_clear_o(pipe_clear_o),
      .score_bcd_o (score_bcd_o),
      .best_bcd_o  (best_bcd_o),
      .game_over_o (game_over_o),
      .state_o     (state_o)
   );
   typedef struct {int cyc; logic [23:0] v;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0, cyc = 0, clears = 0;
   // reference model: phase number, decimal score and best, tick counts
   int m_ph, m_cnt, m_score, m_best, m_run;
   bit m_clear, m_s1, m_s2, m_db, m_pr;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction
   function automatic logic [23:0] m_out();
      return {3'(m_ph), m_ph <= 1, m_ph == 2 || m_ph == 3, m_ph == 2, m_clear, m_ph == 4,
              bcd(m_score), bcd(m_best)};
   endfunction
   task automatic model_reset();
      m_ph = 0; m_cnt = 0; m_score = 0; m_best = 0; m_run = 0;
      m_clear = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_pr = 0;
   endtask
   task automatic model_edge(input bit t, input bit b, input bit p, input bit h, input int yy);
      bit lvl, np;
      lvl = m_s2; m_s2 = m_s1; m_s1 = b; np = 0;
      if (lvl != m_db) begin
         m_run++;
         if (m_run == 16) begin m_db = lvl; m_run = 0; np = lvl; end
      end else m_run = 0;
      m_clear = 0;
      case (m_ph)
         0: if (m_pr) begin m_ph = 1; m_cnt = 0; m_score = 0; m_clear = 1; end
         1: if (t) begin m_cnt++; if (m_cnt == 60) begin m_ph = 2; m_cnt = 0; end end
         2: if (h || yy >= 424) begin m_ph = 3; m_cnt = 0; end
            else if (p && m_score < 99) m_score++;
         3: if (t) begin
               m_cnt++;
               if (m_cnt == 45) begin m_ph = 4; if (m_score > m_best) m_best = m_score; end
            end
         default: if (m_pr) m_ph = 0;
      endcase
      m_pr = np;
   endtask
   task automatic step(input bit t, input bit b, input bit p, input bit h, input int yy);
      @(posedge clk);
      #1;
      tick = t; btn = b; pass = p; hit = h; y = 10'(yy);
      model_edge(t, b, p, h, yy);
      sb.push_back('{cyc + 1, m_out()});
   endtask
   task automatic bg(input bit b);
      bit p, h;
      int yy;
      p = (m_ph != 2) && ($urandom % 2 == 1);
      h = (m_ph != 2) && ($urandom % 3 == 0);
      yy = (m_ph == 2) ? int'($urandom % 424) : int'($urandom % 1024);
      step(bit'($urandom % 2), b, p, h, yy);
   endtask
   task automatic press_btn();
      repeat (40) bg(1);
      repeat (24) bg(0);
   endtask
   task automatic wait_ph(input int ph);
      int n = 0;
      while (m_ph != ph && n < 3000) begin bg(0); n++; end
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL wait_state: stuck at model phase %0d, required %0d", m_ph, ph);
      end
      bg(0);
   endtask
   task automatic passes(input int n);
      repeat (n) begin
         step(bit'($urandom % 2), 0, 1, 0, int'($urandom % 424));
         repeat ($urandom % 3) bg(0);
      end
      bg(0);
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (pipe_clear_o) clears++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if ({state_o, bird_hold_o, bird_run_o, pipe_run_o, pipe_clear_o, game_over_o,
              score_bcd_o, best_bcd_o} !== e.v) begin
            errors++;
            $display("FAIL outputs cyc %0d: got %h required %h", cyc,
                     {state_o, bird_hold_o, bird_run_o, pipe_run_o, pipe_clear_o, game_over_o,
                      score_bcd_o, best_bcd_o}, e.v);
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      int c0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_state", state_o, 0);
      chk("rst_hold", bird_hold_o, 1);
      chk("rst_run", {bird_run_o, pipe_run_o, pipe_clear_o, game_over_o}, 0);
      chk("rst_scores", {score_bcd_o, best_bcd_o}, 0);
      // bouncing button never settles
      for (int i = 0; i < 20; i++) repeat (5) bg(i % 2 == 0);
      repeat (25) bg(0);
      chk("bounce_state", state_o, 0);
      chk("bounce_clears", clears, 0);
      // game A: held start button, pass+hit coincidence
      c0 = clears;
      repeat (40) bg(1);
      chk("start_state", state_o, 1);
      repeat (24) bg(0);
      chk("one_clear", clears - c0, 1);
      press_btn();
      wait_ph(2);
      chk("play_state", state_o, 2);
      chk("play_runs", {bird_run_o, pipe_run_o}, 2'b11);
      passes(5);
      step(1, 0, 1, 1, 100);
      bg(0);
      chk("hit_pass_score", score_bcd_o, 8'h05);
      chk("hit_pass_state", state_o, 3);
      wait_ph(4);
      chk("over_a", {state_o, game_over_o}, {3'd4, 1'b1});
      chk("best_a", best_bcd_o, 8'h05);
      press_btn();
      chk("over_to_idle", state_o, 0);
      // game B: ground boundary
      press_btn();
      wait_ph(2);
      passes(7);
      repeat (5) step(bit'($urandom % 2), 0, 0, 0, 423);
      chk("ground_423", state_o, 2);
      step(bit'($urandom % 2), 0, 0, 0, 424);
      bg(0);
      chk("ground_424", {state_o, pipe_run_o, bird_run_o}, {3'd3, 1'b0, 1'b1});
      wait_ph(4);
      chk("best_b", {best_bcd_o, game_over_o}, {8'h07, 1'b1});
      press_btn();
      // game C: lower score keeps best
      press_btn();
      wait_ph(2);
      passes(3);
      step(0, 0, 0, 1, 50);
      wait_ph(4);
      chk("score_c", score_bcd_o, 8'h03);
      chk("best_c", best_bcd_o, 8'h07);
      press_btn();
      // game D: BCD carry then asynchronous reset mid-play
      press_btn();
      wait_ph(2);
      passes(11);
      chk("score_11", score_bcd_o, 8'h11);
      passes(1);
      chk("score_12", score_bcd_o, 8'h12);
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      tick = 0; btn = 0; pass = 0; hit = 0; y = '0;
      #1;
      chk("async_state", state_o, 0);
      chk("async_scores", {score_bcd_o, best_bcd_o}, 0);
      chk("async_hold", bird_hold_o, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      // game E: saturation at 99
      press_btn();
      wait_ph(2);
      passes(99);
      chk("score_99", score_bcd_o, 8'h99);
      passes(1);
      chk("score_sat", score_bcd_o, 8'h99);
      step(0, 0, 0, 1, 50);
      wait_ph(4);
      chk("best_99", best_bcd_o, 8'h99);
      repeat (3) bg(0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
